l2_fill_arbiter: RTL and testbench
==================================

// Module: l2_fill_arbiter
// PURPOSE
//  Shares the single next-level (L2/memory) port between instruction- and data-cache miss paths.
//  Captures one line request at a time, round-robin between requesters.
//  Drives the memory req/gnt handshake, then waits for the response.
//  Pulses done back to the owning cache; keeps grant, conflict and timeout statistics.
// PARAMETERS
//  ADDR_W   26    line-address width (address[31:6])
//  TIMEOUT  255   max cycles in WAIT_RESP before abort; range 1..65535
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  ic_req       in   1       icache miss request, level-held until ic_ack
//  ic_addr      in   ADDR_W  icache line address
//  ic_ack       out  1       1-cycle pulse: icache request captured
//  ic_done      out  1       1-cycle pulse: icache fill complete (or aborted)
//  dc_req       in   1       dcache request, level-held until dc_ack
//  dc_addr      in   ADDR_W  dcache line address
//  dc_we        in   1       1 = dcache writeback, 0 = fill
//  dc_ack       out  1       1-cycle pulse: dcache request captured
//  dc_done      out  1       1-cycle pulse: dcache transfer complete (or aborted)
//  mem_req      out  1       request to memory; held until mem_gnt
//  mem_addr     out  ADDR_W  captured line address; stable while mem_req=1
//  mem_we       out  1       captured write flag (always 0 for icache)
//  mem_gnt      in   1       memory accepted request
//  mem_resp     in   1       memory transfer complete (1-cycle pulse)
//  timeout_err  out  1       sticky: a transfer hit TIMEOUT
//  ic_grants    out  32      icache captures, saturating
//  dc_grants    out  32      dcache captures, saturating
//  conflicts    out  32      IDLE edges with ic_req&dc_req both high, saturating
// BEHAVIOUR
//  Reset:
//   - Outputs, counters, timeout_err, mem_addr, mem_we all 0.
//   - state=IDLE; last_grant=DC, so icache wins the first conflict.
//   - Reset in any state aborts silently: mem_req drops next cycle, no done pulse.
//  FSM states: IDLE, ISSUE, WAIT_RESP.
//  IDLE, at the clock edge:
//   - Only ic_req high -> capture icache; only dc_req high -> capture dcache.
//   - Both high -> capture the requester != last_grant; conflicts+1.
//   - On capture: owner, mem_addr and mem_we (dc_we for dcache, 0 for icache) registered;
//     last_grant=owner; owner grant counter +1; go to ISSUE.
//  ISSUE:
//   - Owner ack and mem_req both high, first cycle only for ack.
//   - mem_req stays high and mem_addr/mem_we stay stable until mem_gnt is sampled high.
//   - mem_gnt -> WAIT_RESP with wait counter cleared to 0.
//   - No timeout in ISSUE.
//  WAIT_RESP:
//   - mem_req=0; wait counter +1 per cycle.
//   - mem_resp -> owner done pulses for 1 cycle; go to IDLE.
//   - Counter reaching TIMEOUT without mem_resp -> timeout_err=1 (sticky until reset);
//     owner done pulses; go to IDLE.
//   - mem_resp on the same edge the counter reaches TIMEOUT counts as success, no error.
//  Latency:
//   - Request edge t -> ack and mem_req at cycle t+1.
//   - mem_resp at edge r -> done at cycle r+1, state IDLE at r+1.
//   - New capture no earlier than edge r+1, so minimum 1 dead cycle between transfers.
//  Ignored inputs: mem_gnt outside ISSUE; mem_resp outside WAIT_RESP.
//  Requesters: may drop req once ack is seen; a req still high in IDLE is captured again.
//  Counters: saturate at 32'hFFFF_FFFF and never wrap.
//  Done pulses: at most one of ic_done/dc_done per cycle; never both acks in the same cycle.
// TESTING
//  1. ic_req with addr 26'h0ABCDE; mem_gnt same cycle; mem_resp 3 cycles later
//     -> ic_ack at t+1; mem_addr=0ABCDE; ic_done 1 cycle after resp; ic_grants=1.
//  2. ic_req and dc_req(we=1) raised together after reset
//     -> icache served first, then dcache with mem_we=1; conflicts=1; ic_grants=dc_grants=1.
//  3. Both requests held through 4 transfers
//     -> grants alternate IC,DC,IC,DC; conflicts=4; exactly one dead cycle after each done.
//  4. mem_gnt held low 5 cycles
//     -> mem_req high 5+ cycles with mem_addr constant; no timeout_err.
//  5. TIMEOUT=4, mem_resp never arrives
//     -> owner done after 4 WAIT cycles; timeout_err=1 and remains set across next good transfer.
//  6. reset asserted in WAIT_RESP, then mem_resp
//     -> no done pulse; all counters 0; next ic_req captured normally.

Source files
------------

// File: rtl/l2_fill_arbiter.sv
// l2_fill_arbiter
//   Shares the single next-level (L2/memory) port between the icache and
//   dcache miss paths. It captures one line request at a time, choosing
//   round-robin when both caches ask on the same edge. It then runs the
//   mem_req/mem_gnt handshake, waits for mem_resp (bounded by TIMEOUT),
//   and pulses done back to the cache that owns the transfer. It also keeps
//   saturating grant and conflict counters and a sticky timeout flag.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr      icache miss request (level) and line address
//   ic_ack, ic_done     1-cycle pulses: request captured / fill finished
//   dc_req/dc_addr/dc_we dcache request, line address, writeback flag
//   dc_ack, dc_done     1-cycle pulses: request captured / transfer finished
//   mem_req/addr/we     memory request, held with stable addr/we until mem_gnt
//   mem_gnt, mem_resp   memory accept, memory transfer-complete pulse
//   timeout_err         sticky: some transfer was aborted by TIMEOUT
//   ic_grants, dc_grants, conflicts  32-bit saturating statistics
module l2_fill_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_we,
  output logic              dc_ack,
  output logic              dc_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_gnt,
  input  logic              mem_resp,
  output logic              timeout_err,
  output logic [31:0]       ic_grants,
  output logic [31:0]       dc_grants,
  output logic [31:0]       conflicts
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [15:0] wcnt;
  logic [15:0] wcnt_nxt;
  logic        pick_dc;
  logic        any_req;
  logic        wait_end;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // dcache wins when it is alone, or when both ask and icache had the last grant.
  assign any_req  = ic_req | dc_req;
  assign pick_dc  = dc_req & (~ic_req | (last_grant == OWN_IC));
  assign wcnt_nxt = wcnt + 16'd1;
  // A response on the same edge the counter would hit the limit is a success.
  assign wait_end = mem_resp | (wcnt_nxt == TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_IC;
      last_grant  <= OWN_DC;
      wcnt        <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_done     <= 1'b0;
      dc_done     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      timeout_err <= 1'b0;
      ic_grants   <= '0;
      dc_grants   <= '0;
      conflicts   <= '0;
    end else begin
      // acks and dones are single-cycle pulses; they are re-asserted only by the
      // transition that produces them
      ic_ack  <= 1'b0;
      dc_ack  <= 1'b0;
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick_dc;
            last_grant <= pick_dc;
            mem_addr   <= pick_dc ? dc_addr : ic_addr;
            mem_we     <= pick_dc & dc_we;
            mem_req    <= 1'b1;
            if (pick_dc) begin
              dc_ack    <= 1'b1;
              dc_grants <= sat_inc(dc_grants);
            end else begin
              ic_ack    <= 1'b1;
              ic_grants <= sat_inc(ic_grants);
            end
            if (ic_req & dc_req) conflicts <= sat_inc(conflicts);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // no timeout here: the memory side may stall the grant indefinitely
          if (mem_gnt) begin
            mem_req <= 1'b0;
            wcnt    <= '0;
            state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (wait_end) begin
            if (!mem_resp) timeout_err <= 1'b1;
            if (owner == OWN_DC) dc_done <= 1'b1;
            else                 ic_done <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt_nxt;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_fill_arbiter.sv
// Directed bench for l2_fill_arbiter, built with TIMEOUT=4 so the abort path
// is reachable within a few cycles. A per-cycle vector table covers single
// transfers, the first conflict and round-robin alternation. Hand sequences
// cover the grant stall, timeout, the timeout/response tie, and reset in
// WAIT_RESP.
module tb_l2_fill_arbiter;
  localparam int AW = 26;
  localparam logic [AW-1:0] IA = 26'h0ABCDE;
  localparam logic [AW-1:0] DA = 26'h1234567;

  logic          clk, reset;
  logic          ic_req, dc_req, dc_we, mem_gnt, mem_resp;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic          ic_ack, ic_done, dc_ack, dc_done, mem_req, mem_we, timeout_err;
  logic [31:0]   ic_grants, dc_grants, conflicts;

  int nchk = 0;
  int nerr = 0;

  l2_fill_arbiter #(.ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_done(ic_done),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_ack(dc_ack), .dc_done(dc_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_gnt(mem_gnt), .mem_resp(mem_resp),
    .timeout_err(timeout_err), .ic_grants(ic_grants), .dc_grants(dc_grants),
    .conflicts(conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {ic_req, dc_req, dc_we, mem_gnt, mem_resp}
  // ex  = {ic_ack, dc_ack, mem_req, ic_done, dc_done}
  typedef struct {
    int            grp;
    logic [4:0]    in;
    logic [4:0]    ex;
    logic          ex_we;
    logic [AW-1:0] ex_addr;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp_ic[3], exp_dc[3], exp_cf[3];

  function automatic vec_t mk(int g, logic [4:0] i, logic [4:0] e, logic w, logic [AW-1:0] a);
    vec_t v;
    v.grp = g; v.in = i; v.ex = e; v.ex_we = w; v.ex_addr = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ic_req = 0; dc_req = 0; dc_we = 0; mem_gnt = 0; mem_resp = 0;
    ic_addr = IA; dc_addr = DA;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] ei, input logic [31:0] ed,
                         input logic [31:0] ec);
    chk({nm, ".ic_grants"}, ic_grants, ei);
    chk({nm, ".dc_grants"}, dc_grants, ed);
    chk({nm, ".conflicts"}, conflicts, ec);
  endtask

  initial begin
    reset = 1;
    clr_in();

    // group 0: single icache transfer, response 3 cycles after the grant
    tbl.push_back(mk(0, 5'b10000, 5'b10100, 1'b0, IA));
    tbl.push_back(mk(0, 5'b00010, 5'b00000, 1'b0, '0));
    tbl.push_back(mk(0, 5'b00000, 5'b00000, 1'b0, '0));
    tbl.push_back(mk(0, 5'b00000, 5'b00000, 1'b0, '0));
    tbl.push_back(mk(0, 5'b00001, 5'b00010, 1'b0, '0));
    tbl.push_back(mk(0, 5'b00000, 5'b00000, 1'b0, '0));
    // group 1: simultaneous requests after reset, icache first, then dcache writeback
    tbl.push_back(mk(1, 5'b11100, 5'b10100, 1'b0, IA));
    tbl.push_back(mk(1, 5'b01110, 5'b00000, 1'b0, '0));
    tbl.push_back(mk(1, 5'b01101, 5'b00010, 1'b0, '0));
    tbl.push_back(mk(1, 5'b01100, 5'b01100, 1'b1, DA));
    tbl.push_back(mk(1, 5'b00010, 5'b00000, 1'b0, '0));
    tbl.push_back(mk(1, 5'b00001, 5'b00001, 1'b0, '0));
    tbl.push_back(mk(1, 5'b00000, 5'b00000, 1'b0, '0));
    // group 2: both held for 4 transfers; each done cycle is followed directly by
    // the next ack, so exactly one dead cycle separates transfers
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(2, 5'b11100, 5'b10100, 1'b0, IA));
      tbl.push_back(mk(2, 5'b11110, 5'b00000, 1'b0, '0));
      tbl.push_back(mk(2, 5'b11101, 5'b00010, 1'b0, '0));
      tbl.push_back(mk(2, 5'b11100, 5'b01100, 1'b1, DA));
      tbl.push_back(mk(2, 5'b11110, 5'b00000, 1'b0, '0));
      tbl.push_back(mk(2, 5'b11101, 5'b00001, 1'b0, '0));
    end
    tbl.push_back(mk(2, 5'b00000, 5'b00000, 1'b0, '0));
    exp_ic = '{32'd1, 32'd1, 32'd2};
    exp_dc = '{32'd0, 32'd1, 32'd2};
    exp_cf = '{32'd0, 32'd1, 32'd4};

    // reset state
    do_reset();
    chk("rst.pulses", {ic_ack, dc_ack, mem_req, ic_done, dc_done}, 5'b0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.timeout_err", timeout_err, 1'b0);
    chk_cnt("rst", 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0 && tbl[i].grp != tbl[i-1].grp) begin
        chk_cnt($sformatf("grp%0d", tbl[i-1].grp), exp_ic[tbl[i-1].grp],
                exp_dc[tbl[i-1].grp], exp_cf[tbl[i-1].grp]);
        do_reset();
      end
      {ic_req, dc_req, dc_we, mem_gnt, mem_resp} = tbl[i].in;
      tick();
      chk($sformatf("vec%0d.outs", i), {ic_ack, dc_ack, mem_req, ic_done, dc_done}, tbl[i].ex);
      if (tbl[i].ex[2]) begin
        chk($sformatf("vec%0d.mem_addr", i), mem_addr, tbl[i].ex_addr);
        chk($sformatf("vec%0d.mem_we", i), mem_we, tbl[i].ex_we);
      end
    end
    chk_cnt("grp2", exp_ic[2], exp_dc[2], exp_cf[2]);
    chk("grp2.timeout_err", timeout_err, 1'b0);
    clr_in();

    // grant stalled for 5 cycles: request and address must hold, no timeout in ISSUE
    do_reset();
    ic_req = 1;
    tick();
    chk("stall.ack", ic_ack, 1'b1);
    ic_req = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d.req_ack", k), {mem_req, ic_ack}, 2'b10);
      chk($sformatf("stall%0d.addr", k), mem_addr, IA);
    end
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("stall.req_drop", mem_req, 1'b0);
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("stall.done", ic_done, 1'b1);
    chk("stall.timeout_err", timeout_err, 1'b0);

    // timeout: no response, dcache done after 4 WAIT cycles, error stays sticky
    do_reset();
    dc_req = 1;
    tick();
    chk("to.ack", dc_ack, 1'b1);
    dc_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("to.wait%0d", k), {dc_done, timeout_err}, 2'b00);
    end
    tick();
    chk("to.done", {ic_done, dc_done}, 2'b01);
    chk("to.err", timeout_err, 1'b1);
    tick();
    ic_req = 1;
    tick();
    chk("to.next_ack", ic_ack, 1'b1);
    ic_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("to.next_done", ic_done, 1'b1);
    chk("to.err_sticky", timeout_err, 1'b1);

    // response on the same edge the counter reaches TIMEOUT is a success
    do_reset();
    ic_req = 1;
    tick();
    ic_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    for (int k = 0; k < 3; k++) tick();
    chk("tie.no_done_yet", ic_done, 1'b0);
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("tie.done", ic_done, 1'b1);
    chk("tie.no_err", timeout_err, 1'b0);

    // reset during WAIT_RESP aborts silently
    do_reset();
    ic_req = 1;
    tick();
    ic_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rstw.after", {mem_req, ic_done, dc_done}, 3'b000);
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("rstw.no_done", {ic_done, dc_done}, 2'b00);
    chk_cnt("rstw", 0, 0, 0);
    ic_req = 1;
    tick();
    ic_req = 0;
    chk("rstw.recapture", {ic_ack, mem_req}, 2'b11);
    chk("rstw.ic_grants", ic_grants, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
